pipe_instr_fetch: RTL

// Instruction-fetch front end of the pipelined MIPS CPU. Drives the Avalon-style instruction

---
 rtl/pipe_instr_fetch_if.sv | 27 ++
 rtl/pipe_instr_fetch.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_instr_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_instr_fetch_if
// Description : Avalon-style instruction memory port (fetch master <-> memory).
// Revision    : 1.0
// ============================================================================
interface pipe_instr_fetch_if;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_waitrequest,
        input  avm_readdata
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_waitrequest,
        output avm_readdata
    );
endinterface
`default_nettype wire

// File: rtl/pipe_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : pipe_instr_fetch
// Description : Instruction fetch front end: PC tracking, memory requests,
//               instruction buffer, redirects and halt-on-jump-to-zero.
// Revision    : 1.0
// ============================================================================
module pipe_instr_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    parameter int          FIFO_DEPTH   = 2
) (
    input  wire logic              clk,
    input  wire logic              reset,
    pipe_instr_fetch_if.master     avm,
    input  wire logic              redirect_valid,
    input  wire logic [31:0]       redirect_pc,
    input  wire logic              stall,
    output logic                   instr_valid,
    output logic [31:0]            instr_out,
    output logic [31:0]            instr_pc,
    output logic                   fetch_fault,
    output logic                   active
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] C_DEPTH = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        HALT = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [31:0]     resp_pc_q, resp_pc_d;
    logic [31:0]     tgt_q, tgt_d;
    logic            tgt_pend_q, tgt_pend_d;
    logic            stale_q, stale_d;
    logic            halt_pend_q, halt_pend_d;
    logic            fault_q, fault_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     word_q [FIFO_DEPTH];
    logic [31:0]     word_d [FIFO_DEPTH];
    logic [31:0]     wpc_q  [FIFO_DEPTH];
    logic [31:0]     wpc_d  [FIFO_DEPTH];

    logic            w_accept;
    logic            w_push;
    logic            w_pop;
    logic            w_space;
    logic [31:0]     w_tgt;
    logic            w_tgt_zero;

    assign w_accept   = (state_q == REQ) && !avm.avm_waitrequest;
    assign w_pop      = (count_q != '0) && !stall;
    assign w_push     = (state_q == RESP) && !stale_q && !redirect_valid;
    assign w_tgt      = {redirect_pc[31:2], 2'b00};
    assign w_tgt_zero = (redirect_pc == 32'd0);
    assign w_space    = (count_d < C_DEPTH);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        word_d   = word_q;
        wpc_d    = wpc_q;
        fault_d  = fault_q;

        if (redirect_valid) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            if (redirect_pc[1:0] != 2'b00) begin
                fault_d = 1'b1;
            end
        end else begin
            if (w_push) begin
                word_d[wr_ptr_q] = avm.avm_readdata;
                wpc_d[wr_ptr_q]  = resp_pc_q;
                wr_ptr_d         = wr_ptr_q + AW'(1);
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (w_push && !w_pop) begin
                count_d = count_q + CW'(1);
            end else if (!w_push && w_pop) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        resp_pc_d   = resp_pc_q;
        tgt_d       = tgt_q;
        tgt_pend_d  = tgt_pend_q;
        stale_d     = stale_q;
        halt_pend_d = halt_pend_q;

        case (state_q)
            IDLE: begin
                if (redirect_valid) begin
                    pc_d    = w_tgt;
                    state_d = w_tgt_zero ? HALT : REQ;
                end else if (w_space) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (w_accept) begin
                    resp_pc_d  = pc_q;
                    state_d    = RESP;
                    pc_d       = tgt_pend_q ? tgt_q : pc_q + 32'd4;
                    tgt_pend_d = 1'b0;
                end
                // A held request keeps its address on the bus; the new target waits in tgt_q.
                if (redirect_valid) begin
                    stale_d     = 1'b1;
                    halt_pend_d = w_tgt_zero;
                    if (w_accept) begin
                        pc_d = w_tgt;
                    end else begin
                        tgt_d      = w_tgt;
                        tgt_pend_d = 1'b1;
                    end
                end
            end
            RESP: begin
                stale_d     = 1'b0;
                halt_pend_d = 1'b0;
                if (redirect_valid) begin
                    pc_d    = w_tgt;
                    state_d = w_tgt_zero ? HALT : REQ;
                end else if (halt_pend_q) begin
                    state_d = HALT;
                end else begin
                    state_d = w_space ? REQ : IDLE;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            pc_q        <= RESET_VECTOR;
            resp_pc_q   <= '0;
            tgt_q       <= '0;
            tgt_pend_q  <= 1'b0;
            stale_q     <= 1'b0;
            halt_pend_q <= 1'b0;
            fault_q     <= 1'b0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                word_q[i] <= '0;
                wpc_q[i]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            resp_pc_q   <= resp_pc_d;
            tgt_q       <= tgt_d;
            tgt_pend_q  <= tgt_pend_d;
            stale_q     <= stale_d;
            halt_pend_q <= halt_pend_d;
            fault_q     <= fault_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            word_q      <= word_d;
            wpc_q       <= wpc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            a_no_overflow: assert (!(w_push && !w_pop && (count_q == C_DEPTH)));
        end
    end

    assign avm.avm_read    = (state_q == REQ);
    assign avm.avm_address = pc_q;
    assign instr_valid     = (count_q != '0);
    assign instr_out       = word_q[rd_ptr_q];
    assign instr_pc        = wpc_q[rd_ptr_q];
    assign fetch_fault     = fault_q;
    assign active          = (state_q != HALT);
endmodule
`default_nettype wire
